// File: rtl/xoodoo_perm_core.sv
// Xoodoo[n] permutation engine: UNROLL rounds per clock, runtime round count,
// valid/ready request and result handshakes with the result held until consumed.
module xoodoo_perm_core #(
    parameter int MAX_ROUNDS = 12,
    parameter int UNROLL     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [383:0] state_in,
    input  logic [3:0]   n_rounds,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [383:0] state_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nxt;
    logic [383:0]   work_r;
    logic [383:0]   work_nxt;
    logic [383:0]   result_r;
    logic [383:0]   result_nxt;
    logic [3:0]     rem_r;
    logic [3:0]     rem_nxt;
    logic           out_valid_r;
    logic           out_valid_nxt;
    logic           in_ready_r;
    logic           busy_r;
    logic [383:0]   chain_s;
    logic [3:0]     n_clamped_s;

    function automatic logic [31:0] rotl32(input logic [31:0] v, input int d);
        return (v << d) | (v >> (32 - d));
    endfunction

    // Lane x moves to x+dx mod 4 (a 128-bit rotate by whole lanes), then each lane rotates by dz.
    function automatic logic [127:0] plane_shift(input logic [127:0] p, input int dx, input int dz);
        logic [127:0] m;
        m = (p << (32 * dx)) | (p >> (128 - 32 * dx));
        return {rotl32(m[127:96], dz), rotl32(m[95:64], dz),
                rotl32(m[63:32], dz), rotl32(m[31:0], dz)};
    endfunction

    function automatic logic [31:0] round_const(input logic [3:0] idx);
        case (idx)
            4'd0:    return 32'h0000_0058;
            4'd1:    return 32'h0000_0038;
            4'd2:    return 32'h0000_03C0;
            4'd3:    return 32'h0000_00D0;
            4'd4:    return 32'h0000_0120;
            4'd5:    return 32'h0000_0014;
            4'd6:    return 32'h0000_0060;
            4'd7:    return 32'h0000_002C;
            4'd8:    return 32'h0000_0380;
            4'd9:    return 32'h0000_00F0;
            4'd10:   return 32'h0000_01A0;
            4'd11:   return 32'h0000_0012;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [383:0] xoodoo_round(input logic [383:0] a, input logic [31:0] c);
        logic [127:0] a0, a1, a2, p, e, b0, b1, b2;
        a0 = a[127:0];
        a1 = a[255:128];
        a2 = a[383:256];
        p  = a0 ^ a1 ^ a2;
        e  = plane_shift(p, 1, 5) ^ plane_shift(p, 1, 14);
        a0 = a0 ^ e;
        a1 = plane_shift(a1 ^ e, 1, 0);
        a2 = plane_shift(a2 ^ e, 0, 11);
        a0[31:0] = a0[31:0] ^ c;
        // chi reads only the pre-chi planes
        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a0);
        b2 = a2 ^ (~a0 & a1);
        return {plane_shift(b2, 2, 8), plane_shift(b1, 0, 1), b0};
    endfunction

    // Unrolled round chain; stages beyond the remaining count pass the state through untouched.
    always_comb begin
        chain_s = work_r;
        for (int s = 0; s < UNROLL; s++) begin
            chain_s = (rem_r > 4'(s))
                    ? xoodoo_round(chain_s, round_const(4'd12 - rem_r + 4'(s)))
                    : chain_s;
        end
    end

    // Request round count saturated at the table size.
    always_comb begin
        n_clamped_s = (n_rounds > 4'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : n_rounds;
    end

    // Next-state and datapath update selection.
    always_comb begin
        state_nxt     = state_r;
        work_nxt      = work_r;
        result_nxt    = result_r;
        rem_nxt       = rem_r;
        out_valid_nxt = out_valid_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    work_nxt  = state_in;
                    rem_nxt   = n_clamped_s;
                    state_nxt = (n_clamped_s == 4'd0) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                work_nxt = chain_s;
                if (rem_r <= 4'(UNROLL)) begin
                    rem_nxt   = 4'd0;
                    state_nxt = ST_DONE;
                end else begin
                    rem_nxt   = rem_r - 4'(UNROLL);
                end
            end
            ST_DONE: begin
                // First DONE cycle loads the output register; afterwards it is held until taken.
                if (!out_valid_r) begin
                    out_valid_nxt = 1'b1;
                    result_nxt    = work_r;
                end else if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end else begin
                    out_valid_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                out_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, working register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            work_r      <= 384'd0;
            result_r    <= 384'd0;
            rem_r       <= 4'd0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            work_r      <= work_nxt;
            result_r    <= result_nxt;
            rem_r       <= rem_nxt;
            out_valid_r <= out_valid_nxt;
            in_ready_r  <= (state_nxt == ST_IDLE);
            busy_r      <= (state_nxt == ST_RUN);
        end
    end

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign state_out = result_r;

endmodule

// File: doc/xoodoo_perm_core.md
Name: xoodoo_perm_core

Overview:
- Parametrised Xoodoo[n] permutation engine for the Xoodyak datapath.
- Successor to the fixed 12-round, one-round-per-cycle core, with three additions:
  - a compile-time unroll factor (rounds per clock);
  - a runtime round count (1..12, plus 0 for pass-through);
  - valid/ready handshakes on both input and output, with the result held until consumed.

Parameters:
- MAX_ROUNDS, 12, number of round constants in the table; legal n_rounds range is 0..MAX_ROUNDS.
- UNROLL, 1, rounds computed per clock in RUN; legal values 1, 2, 3, 4, 6, 12.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  a request is present on state_in/n_rounds.
- in_ready  out  1  core can accept a request.
- state_in  in  384  input state.
- n_rounds  in  4  rounds to apply; sampled with state_in.
- out_valid  out  1  state_out holds a finished result.
- out_ready  in  1  consumer accepts state_out.
- state_out  out  384  permuted state.
- busy  out  1  high in RUN.

Behaviour:
- State layout: plane y (0..2) = bits [128y+127:128y]. Lane x (0..3) = plane bits [32x+31:32x]. Bit z = bit z of the lane (LSB is z=0).
- Notation: "<<<(dx,dz)" moves lane x to x+dx mod 4 and rotates each lane left by dz.
- Round, in this order:
  - theta: P = A0^A1^A2; E = P<<<(1,5) ^ P<<<(1,14); every Ay ^= E.
  - rho-west: A1 = A1<<<(1,0); A2 = A2<<<(0,11).
  - iota: lane (x=0, y=0) ^= C.
  - chi, using the pre-chi values on the right-hand side: A0 ^= ~A1&A2; A1 ^= ~A2&A0; A2 ^= ~A0&A1.
  - rho-east: A1 = A1<<<(0,1); A2 = A2<<<(2,8).
- Round constants C, round index 0..11: 0x58, 0x38, 0x3C0, 0xD0, 0x120, 0x14, 0x60, 0x2C, 0x380, 0xF0, 0x1A0, 0x12.
- An n-round request runs indices 12-n .. 11, in order (Xoodoo[n] definition).
- n_rounds > 12 is treated as 12.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE:
    - in_ready=1.
    - On an in_valid handshake: register state_in into the working register and set remaining = min(n_rounds, 12).
    - If remaining=0, go straight to DONE; otherwise go to RUN.
  - RUN:
    - Each cycle applies k = min(UNROLL, remaining) rounds through the UNROLL-deep combinational chain.
    - Unused stages (k < UNROLL, final partial cycle) are bypassed; they must not alter the state.
    - remaining -= k; go to DONE when it reaches 0.
    - in_ready=0 and busy=1 throughout RUN.
  - DONE:
    - out_valid=1; state_out = working register, held stable.
    - Leave on out_valid & out_ready; return to IDLE.
- Latency: request accepted at edge t. out_valid rises after edge t + 1 + ceil(n/UNROLL) for n ≥ 1, and after edge t + 1 for n = 0.
- Throughput:
  - in_ready is low in RUN and DONE, so there is no overlap between requests.
  - The next request can be accepted on the edge after the out handshake.
- in_valid in RUN or DONE is ignored, with no side effects.
- out_ready while not in DONE is ignored.
- Reset, asynchronous and at any time, including mid-RUN:
  - FSM goes to IDLE; working register, state_out and remaining go to 0.
  - out_valid=0, busy=0, in_ready=1 (once reset is deasserted).
  - A partially computed result is discarded; it is never presented.
- Constant-index arithmetic: the round index for stage s of a RUN cycle is 12 - remaining + s, 4 bits wide, never exceeding 11.

Test Plan:
- Reset then idle: reset pulse mid-sim -> in_ready=1, out_valid=0, busy=0, state_out=0 asynchronously on reset assertion.
- Zero state, n_rounds=1, UNROLL=1 -> out_valid at t+2. state_out has plane0 lane0=0x00000012, plane1 lane0=0x00000024; all other lanes 0.
- Random states, n_rounds=12, UNROLL in {1,3,4,12} -> state_out matches the C golden model. out_valid at t+13/5/4/2 respectively.
- n_rounds=0 and n_rounds=15 -> n=0: state_out==state_in, out_valid at t+1. n=15: identical to n=12 result and latency.
- Partial last cycle: UNROLL=4, n_rounds=6 -> 2 RUN cycles; result equals golden Xoodoo[6] (indices 6..11).
- Backpressure and abort:
  - out_ready held 0 for 10 cycles -> state_out stable, in_ready=0, extra in_valid ignored.
  - reset asserted in the 3rd RUN cycle -> no out_valid; a fresh request afterwards yields the correct result.
